// File: rtl/decoder_3_8_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready handshakes, an 8-step
// self-test sweep and a saturating count of completed output transfers.
module decoder_3_8_seq #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2:0]         i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sweep_start,
    output logic               sweep_busy,
    output logic [7:0]         q,
    output logic               q_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           q_q, q_d;
    logic                 q_valid_q, q_valid_d;
    logic [2:0]           step_q, step_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 accept;
    logic                 xfer;
    logic [2:0]           step_nxt;

    assign sweep_busy = (state_q == SWEEP);
    assign in_ready   = en & ~sweep_busy & ~sweep_start & (~q_valid_q | out_ready);
    assign accept     = in_valid & in_ready;
    assign xfer       = q_valid_q & out_ready;
    assign step_nxt   = step_q + 3'd1;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d   = state_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        step_d    = step_q;

        case (state_q)
            IDLE: begin
                if (sweep_start && en) begin
                    state_d   = SWEEP;
                    q_d       = 8'h01;
                    q_valid_d = 1'b1;
                    step_d    = 3'd0;
                end else if (accept) begin
                    state_d   = HOLD;
                    q_d       = 8'd1 << i;
                    q_valid_d = 1'b1;
                end
            end
            HOLD: begin
                // In HOLD an accept can only happen alongside a transfer.
                if (accept) begin
                    q_d       = 8'd1 << i;
                    q_valid_d = 1'b1;
                end else if (xfer) begin
                    state_d   = IDLE;
                    q_valid_d = 1'b0;
                end
            end
            SWEEP: begin
                if (xfer) begin
                    if (step_q == 3'd7) begin
                        state_d   = IDLE;
                        q_valid_d = 1'b0;
                        step_d    = 3'd0;
                    end else if (en) begin
                        step_d    = step_nxt;
                        q_d       = 8'd1 << step_nxt;
                    end else begin
                        q_valid_d = 1'b0;
                    end
                end else if (!q_valid_q && en) begin
                    // Resume a paused sweep with the step after the last transferred one.
                    step_d    = step_nxt;
                    q_d       = 8'd1 << step_nxt;
                    q_valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                q_valid_d = 1'b0;
                step_d    = 3'd0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (xfer && (count_q != {COUNT_W{1'b1}}))
            count_d = count_q + COUNT_W'(1);
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            q_q       <= 8'h00;
            q_valid_q <= 1'b0;
            step_q    <= 3'd0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            step_q    <= step_d;
            count_q   <= count_d;
        end
    end

    assign q          = q_q;
    assign q_valid    = q_valid_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_decoder_3_8_seq.sv
// Self-checking bench for decoder_3_8_seq: scoreboard of expected q values,
// plus a second instance with a 3-bit counter to exercise saturation.
module tb_decoder_3_8_seq;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, sweep_start, out_ready;
    logic [2:0] i;

    logic       in_ready, sweep_busy, q_valid;
    logic [7:0] q;
    logic [7:0] xfer_count;

    logic       s_in_ready, s_sweep_busy, s_q_valid;
    logic [7:0] s_q;
    logic [2:0] s_xfer_count;

    decoder_3_8_seq #(.COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .i(i), .in_valid(in_valid),
        .in_ready(in_ready), .sweep_start(sweep_start), .sweep_busy(sweep_busy),
        .q(q), .q_valid(q_valid), .out_ready(out_ready), .xfer_count(xfer_count)
    );

    decoder_3_8_seq #(.COUNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .i(i), .in_valid(in_valid),
        .in_ready(s_in_ready), .sweep_start(sweep_start), .sweep_busy(s_sweep_busy),
        .q(s_q), .q_valid(s_q_valid), .out_ready(out_ready), .xfer_count(s_xfer_count)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         total_xfer = 0;
    logic [7:0] exp_q[$];
    logic [7:0] popped;

    // Scoreboard: every transfer seen must match the oldest expected code.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (!$onehot0(q)) begin
                fails++;
                $display("FAIL onehot: q=%b is neither one-hot nor zero", q);
            end
            if (q_valid && out_ready) begin
                tests++;
                total_xfer++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_xfer: q=%h transferred, none expected", q);
                end else begin
                    popped = exp_q.pop_front();
                    if (q !== popped) begin
                        fails++;
                        $display("FAIL xfer_data: q=%h expected %h", q, popped);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected transfers missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_counts(input string name);
        logic [7:0] e8;
        logic [2:0] e3;
        e8 = (total_xfer > 255) ? 8'd255 : 8'(total_xfer);
        e3 = (total_xfer > 7) ? 3'd7 : 3'(total_xfer);
        tests += 2;
        if (xfer_count !== e8) begin
            fails++;
            $display("FAIL %s count8: got %0d expected %0d", name, xfer_count, e8);
        end
        if (s_xfer_count !== e3) begin
            fails++;
            $display("FAIL %s count3: got %0d expected %0d", name, s_xfer_count, e3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; sweep_start = 1'b0; i = 3'd0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        tests++;
        if ({q, q_valid, sweep_busy, xfer_count, in_ready} !== {8'h00, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL reset: q=%h v=%b busy=%b cnt=%0d rdy=%b expected 00 0 0 0 1",
                     q, q_valid, sweep_busy, xfer_count, in_ready);
        end
        test_counts("reset");
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            i = 3'(k);
            exp_q.push_back(8'd1 << k);
            #1;
            if (k > 0) begin
                tests++;
                if ({q_valid, q} !== {1'b1, 8'(8'd1 << (k - 1))}) begin
                    fails++;
                    $display("FAIL stream_%0d: v=%b q=%h expected 1 %h", k - 1, q_valid, q, 8'd1 << (k - 1));
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        tests++;
        if ({q_valid, q} !== {1'b1, 8'h80}) begin
            fails++;
            $display("FAIL stream_7: v=%b q=%h expected 1 80", q_valid, q);
        end
        tick();
        tests++;
        if (q_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_idle: q_valid=%b expected 0", q_valid);
        end
        wait_drain(4);
        test_counts("stream");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        i = 3'd5;
        exp_q.push_back(8'h20);
        tick();
        i = 3'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if ({q_valid, q, in_ready} !== {1'b1, 8'h20, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold_%0d: v=%b q=%h rdy=%b expected 1 20 0", c, q_valid, q, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        exp_q.push_back(8'h04);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests++;
        if ({q_valid, q} !== {1'b1, 8'h04}) begin
            fails++;
            $display("FAIL bp_next: v=%b q=%h expected 1 04", q_valid, q);
        end
        tick();
        wait_drain(4);
        test_counts("bp");
    endtask

    task automatic test_sweep();
        out_ready = 1'b1;
        in_valid = 1'b1;
        i = 3'd3;
        sweep_start = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL sweep_prio: in_ready=%b expected 0", in_ready);
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(8'd1 << k);
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if ({q_valid, sweep_busy, in_ready, q} !== {1'b1, 1'b1, 1'b0, 8'(8'd1 << k)}) begin
                fails++;
                $display("FAIL sweep_step_%0d: v=%b busy=%b rdy=%b q=%h expected 1 1 0 %h",
                         k, q_valid, sweep_busy, in_ready, q, 8'd1 << k);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        tests++;
        if ({q_valid, sweep_busy, in_ready} !== {1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL sweep_end: v=%b busy=%b rdy=%b expected 0 0 1", q_valid, sweep_busy, in_ready);
        end
        wait_drain(4);
        test_counts("sweep");
    endtask

    task automatic test_sweep_pause();
        out_ready = 1'b1;
        in_valid = 1'b1;
        i = 3'd6;
        sweep_start = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL pause_prio: in_ready=%b expected 0", in_ready);
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(8'd1 << k);
        tick();
        sweep_start = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
        en = 1'b0;
        #1;
        tests++;
        if ({q_valid, q} !== {1'b1, 8'h04}) begin
            fails++;
            $display("FAIL pause_step2: v=%b q=%h expected 1 04", q_valid, q);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if ({q_valid, sweep_busy} !== {1'b0, 1'b1}) begin
                fails++;
                $display("FAIL pause_hold_%0d: v=%b busy=%b expected 0 1", c, q_valid, sweep_busy);
            end
        end
        for (int k = 3; k < 8; k++) exp_q.push_back(8'd1 << k);
        en = 1'b1;
        tick();
        tests++;
        if ({q_valid, q} !== {1'b1, 8'h08}) begin
            fails++;
            $display("FAIL pause_resume: v=%b q=%h expected 1 08", q_valid, q);
        end
        wait_drain(12);
        tick();
        tests++;
        if ({q_valid, sweep_busy} !== {1'b0, 1'b0}) begin
            fails++;
            $display("FAIL pause_end: v=%b busy=%b expected 0 0", q_valid, sweep_busy);
        end
        test_counts("pause");
    endtask

    task automatic test_en_gating();
        en = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        i = 3'd1;
        sweep_start = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL en_ready: in_ready=%b expected 0", in_ready);
        end
        tick();
        sweep_start = 1'b0;
        #1;
        tests++;
        if ({q_valid, sweep_busy} !== {1'b0, 1'b0}) begin
            fails++;
            $display("FAIL en_ignored: v=%b busy=%b expected 0 0", q_valid, sweep_busy);
        end
        en = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(8'h02);
        tick();
        in_valid = 1'b0;
        en = 1'b0;
        #1;
        tests++;
        if ({q_valid, q} !== {1'b1, 8'h02}) begin
            fails++;
            $display("FAIL en_pending: v=%b q=%h expected 1 02", q_valid, q);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (q_valid !== 1'b0) begin
            fails++;
            $display("FAIL en_drain: q_valid=%b expected 0", q_valid);
        end
        en = 1'b1;
        wait_drain(2);
        test_counts("en");
    endtask

    task automatic test_sat_reset();
        bool_found: begin end
        out_ready = 1'b1;
        sweep_start = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(8'd1 << k);
        tick();
        sweep_start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (q_valid && q == 8'h10) break;
            tick();
        end
        tests++;
        if ({q_valid, q} !== {1'b1, 8'h10}) begin
            fails++;
            $display("FAIL sat_step4: v=%b q=%h expected 1 10", q_valid, q);
        end
        rst = 1'b1;
        #1;
        exp_q.delete();
        total_xfer = 0;
        tests++;
        if ({q, q_valid, sweep_busy, xfer_count, s_xfer_count} !== {8'h00, 1'b0, 1'b0, 8'h00, 3'd0}) begin
            fails++;
            $display("FAIL mid_reset: q=%h v=%b busy=%b cnt=%0d cnt3=%0d expected 00 0 0 0 0",
                     q, q_valid, sweep_busy, xfer_count, s_xfer_count);
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({q_valid, sweep_busy, in_ready} !== {1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL post_reset: v=%b busy=%b rdy=%b expected 0 0 1", q_valid, sweep_busy, in_ready);
        end
        test_counts("post_reset");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_sweep();
        test_sweep_pause();
        test_en_gating();
        test_sat_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decoder_3_8_seq.md
Name: decoder_3_8_seq

Overview:
Registered 3-to-8 one-hot decoder with valid/ready handshakes on both input and output. It is the inverse partner of the 8-to-3 encoder, and sits between an encoder-side producer and any consumer of one-hot select lines. It also has a self-test sweep mode that walks q through all eight one-hot codes, 00000001 up to 10000000. A saturating counter tracks completed output transfers.

Parameters:
COUNT_W, 8, width of the saturating output-transfer counter xfer_count.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  enable; gates new input accepts and sweep advance.
i  input  3  binary code to decode.
in_valid  input  1  i is valid this cycle.
in_ready  output  1  decoder accepts i this cycle. Combinational.
sweep_start  input  1  single-cycle request to run the 8-step sweep.
sweep_busy  output  1  high while the sweep is in progress. Registered.
q  output  8  one-hot decoded value. Registered.
q_valid  output  1  q is valid. Registered.
out_ready  input  1  consumer accepts q this cycle.
xfer_count  output  COUNT_W  number of completed q transfers, saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - q=8'h00, q_valid=0, sweep_busy=0, xfer_count=0.
  - Step index=0, state=IDLE.
- Definitions:
  - Input accept = in_valid & in_ready.
  - Output transfer = q_valid & out_ready.
- in_ready = en & ~sweep_busy & ~sweep_start & (~q_valid | out_ready).
  - This is a single-stage pipeline: a new code is accepted in the same cycle that the held q transfers out.
- Latency: input accept at edge N gives q = 1<<i and q_valid=1 after edge N. Latency is 1 cycle.
- q and q_valid hold stable while q_valid=1 and out_ready=0.
- On a transfer with no new accept and no sweep step pending: q_valid goes to 0 and q holds its last value. q contents are ignored when q_valid=0.
- States:
  - IDLE: no output pending (q_valid=0).
  - HOLD: q_valid=1, waiting for transfer.
  - SWEEP: sweep_busy=1.
- IDLE→HOLD on input accept.
- HOLD→IDLE on transfer with no accept.
- HOLD→HOLD on transfer with a simultaneous accept.
- IDLE→SWEEP when sweep_start=1, en=1 and q_valid=0:
  - Next cycle: q=8'h01, q_valid=1, sweep_busy=1, step=0.
  - sweep_start in the same cycle as in_valid: sweep wins, because in_ready is forced to 0.
- sweep_start is ignored when q_valid=1 or sweep_busy=1 or en=0. It is not queued.
- SWEEP operation:
  - Each step k presents q=1<<k with q_valid=1 until transfer.
  - On transfer of step k<7 with en=1: the next cycle presents step k+1. The rate is 1 step per cycle if out_ready is held high.
  - On transfer of step k<7 with en=0: q_valid drops to 0 and the step index holds. Step k+1 is presented the cycle after en returns to 1.
  - On transfer of step 7: q_valid=0, sweep_busy=0, step resets to 0, return to IDLE.
  - Input accepts never occur during SWEEP.
- en=0:
  - Blocks accepts and sweep advance.
  - A pending q still completes its transfer normally.
- xfer_count increments by 1 on every transfer, including sweep steps. It saturates at all-ones and never wraps.
- Reset mid-sweep or mid-hold aborts immediately to the reset values. The pending transfer is lost and is not counted.
- q is always either one-hot or 0. Any other value is a design error.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 → q=00, q_valid=0, sweep_busy=0, xfer_count=0, in_ready=1 (en=1, out_ready=1).
- Streaming decode: out_ready=1, feed i=0..7 back-to-back with in_valid=1 → one cycle later q=01,02,04,08,10,20,40,80 on consecutive cycles; xfer_count=8.
- Backpressure: i=5 accepted with out_ready=0 for 3 cycles → q=20 held and in_ready=0 for those 3 cycles; with out_ready=1, i=2 is accepted in the transfer cycle and the next q=04.
- Sweep: sweep_start pulse with out_ready=1 → q=01..80 on 8 consecutive cycles, sweep_busy=1 throughout, then q_valid=0 and busy=0; in_valid held high meanwhile is never accepted.
- Sweep pause/priority: sweep_start and in_valid in the same cycle → input not accepted and sweep starts; en=0 after step 2 transfers → q_valid=0 until en=1, then q=08.
- Saturation and reset: COUNT_W=3, 10 transfers → xfer_count=7; rst asserted mid-sweep at step 4 → q=00, sweep_busy=0, xfer_count=0 immediately.
